lcd_rx_bus: RTL and testbench
=============================

Name: lcd_rx_bus

Overview:
Parametrised successor of the 8080-style LCD write-bus receiver. Synchronises the asynchronous LCD bus into the i_clk domain and detects WR rising edges. Decodes each write into a command, a parameter or an RGB565 pixel, and supports both 8-bit and 16-bit buses. Sits between the LCD pads and the framebuffer/command-decoder logic, and adds parameter indexing, 8-bit pixel assembly and a frame-start marker.

Parameters:
BUS_WIDTH, 16, LCD data bus width; legal values 8 or 16.
SYNC_STAGES, 2, flip-flop stages in each input synchroniser; legal values 2..4.
CMD_RAMWR, 8'h2C, command that opens a pixel stream and marks frame start.
CMD_RAMWRC, 8'h3C, command that continues a pixel stream without frame start.
PIDX_W, 4, width of the parameter index counter.

Ports:
i_clk  input  1  system clock
i_rst  input  1  reset (one clock; reset is asynchronous and active-high)
i_lcd_wr_async  input  1  LCD write strobe; data is captured on the rising edge
i_lcd_rs_async  input  1  0 = command, 1 = data
i_lcd_cs_n_async  input  1  chip select, active low
i_lcd_rst_n_async  input  1  LCD-side reset, active low
i_lcd_data_async  input  BUS_WIDTH  LCD data bus
o_command  output  8  last command byte
o_command_latch  output  1  1-cycle pulse: o_command updated
o_param  output  8  parameter byte
o_param_idx  output  PIDX_W  index of o_param since the last command (0-based, saturating)
o_param_latch  output  1  1-cycle pulse: o_param/o_param_idx updated
o_rgb565  output  16  assembled pixel
o_rgb565_latch  output  1  1-cycle pulse: pixel valid
o_frame_start  output  1  asserted together with the first o_rgb565_latch after CMD_RAMWR

Behaviour:
- Reset: all outputs are 0. Control synchronisers reset to 1 (WR high, CS_n high, LCD reset high, RS high). Data synchronisers reset to 0. The FSM resets to IDLE, byte phase to 0 and param index to 0.
- Synchronisers: SYNC_STAGES flops on every input bit. Edge detect uses one extra flop on the synced WR. A write event is synced WR = 1, previous = 0 and synced CS_n = 0. RS and data are taken from the same synced cycle.
- Source timing: WR low and high pulse widths must each be at least 2 i_clk periods, and data/RS must be stable SYNC_STAGES+1 cycles before WR rises. Writes violating this are not guaranteed.
- Latency: each latch pulse is registered and asserts exactly 1 cycle after the cycle in which the write event is detected. This is SYNC_STAGES+2 rising edges after the first i_clk edge that samples the pin WR high.
- Command (RS = 0):
  - o_command <= data[7:0]; o_command_latch pulses.
  - Param index and byte phase clear.
  - Next state: CMD_RAMWR -> PIXEL with frame pending set; CMD_RAMWRC -> PIXEL with frame pending cleared; any other command -> PARAM.
- PARAM state, data write: o_param <= data[7:0]; o_param_idx <= current index; o_param_latch pulses. The index then increments, saturating at all-ones.
- IDLE state, data write: ignored; no pulse.
- PIXEL state, BUS_WIDTH = 16: o_rgb565 <= data; o_rgb565_latch pulses.
- PIXEL state, BUS_WIDTH = 8:
  - Phase 0 stores data[7:0] as the high byte with no pulse.
  - Phase 1 outputs {high, data[7:0]}, pulses o_rgb565_latch and returns phase to 0.
- o_frame_start: asserted with the first pixel pulse while frame pending is set. Frame pending then clears.
- CS_n rising (deselect): byte phase clears, discarding any half pixel. FSM state and param index are kept.
- Synced LCD reset low: acts as a synchronous clear of FSM to IDLE, byte phase, param index and frame pending. Write events are ignored while it is low. Output data registers hold their values; latch pulses are 0.
- i_rst asserted mid-operation: immediate asynchronous return to the reset values above, including any latch pulse in flight.
- Upper data bits [15:8] are ignored for commands and params. In 8-bit mode no such bits exist.
- At most one latch pulse is active in any cycle.

Test Plan:
- 16-bit: cmd 0x2A, data 0x00, 0x10, 0x00, 0xEF -> o_command = 0x2A latched once; four param pulses with values 00/10/00/EF and indices 0/1/2/3; no pixel pulse.
- 16-bit: cmd 0x2C, data 0xF800, 0x07E0 -> two pixel pulses; first has o_frame_start = 1, second has o_frame_start = 0; then cmd 0x3C, data 0x001F -> pixel 0x001F with o_frame_start = 0.
- 8-bit: cmd 0x2C, bytes 0xF8, 0x00, 0x07, 0xE0 -> pixels 0xF800 then 0x07E0. Repeat with CS_n toggled high after byte 0xF8 -> that byte is dropped, so bytes 0x12, 0x34 yield 0x1234.
- Latency: SYNC_STAGES = 2 and 3, single command write -> o_command_latch rises exactly 4 and 5 edges after the first sampled WR-high edge respectively.
- Reset: 17 params after cmd 0xB1 -> o_param_idx saturates at 15. LCD reset pulse, then a data write -> no pulse (IDLE). i_rst during a pixel stream -> all outputs 0 in the same cycle.
- CS_n held high with WR toggling and data 0xABCD -> no latch pulses at all.

Source files
------------

// File: rtl/lcd_rx_bus_if.sv
// LCD 8080-style write bus plus decoded outputs.
// Pin side is asynchronous; decoded side is in the receiver clock domain.
interface lcd_rx_bus_if #(
  parameter int BUS_WIDTH = 16,
  parameter int PIDX_W    = 4
);
  logic                 i_lcd_wr_async;
  logic                 i_lcd_rs_async;
  logic                 i_lcd_cs_n_async;
  logic                 i_lcd_rst_n_async;
  logic [BUS_WIDTH-1:0] i_lcd_data_async;
  logic [7:0]           o_command;
  logic                 o_command_latch;
  logic [7:0]           o_param;
  logic [PIDX_W-1:0]    o_param_idx;
  logic                 o_param_latch;
  logic [15:0]          o_rgb565;
  logic                 o_rgb565_latch;
  logic                 o_frame_start;

  modport slave (
    input  i_lcd_wr_async, i_lcd_rs_async, i_lcd_cs_n_async,
    input  i_lcd_rst_n_async, i_lcd_data_async,
    output o_command, o_command_latch, o_param, o_param_idx,
    output o_param_latch, o_rgb565, o_rgb565_latch, o_frame_start
  );

  modport master (
    output i_lcd_wr_async, i_lcd_rs_async, i_lcd_cs_n_async,
    output i_lcd_rst_n_async, i_lcd_data_async,
    input  o_command, o_command_latch, o_param, o_param_idx,
    input  o_param_latch, o_rgb565, o_rgb565_latch, o_frame_start
  );
endinterface

// File: rtl/lcd_rx_bus.sv
// LCD write-bus receiver: synchronises pins, detects WR rising edges,
// decodes commands, indexed parameters and RGB565 pixels (8/16-bit bus).
module lcd_rx_bus #(
  parameter int         BUS_WIDTH   = 16,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CMD_RAMWR   = 8'h2C,
  parameter logic [7:0] CMD_RAMWRC  = 8'h3C,
  parameter int         PIDX_W      = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  lcd_rx_bus_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PARAM, PIXEL} state_t;

  logic [SYNC_STAGES-1:0] wr_sh, rs_sh, cs_sh, lr_sh;
  logic [BUS_WIDTH-1:0]   d_sh [SYNC_STAGES];
  logic wr_s, rs_s, cs_s, lr_s, wr_prev, cs_prev;
  logic ev_q, ev_rs;
  logic [BUS_WIDTH-1:0] ev_data;
  logic [15:0] ev_d16;

  assign wr_s   = wr_sh[SYNC_STAGES-1];
  assign rs_s   = rs_sh[SYNC_STAGES-1];
  assign cs_s   = cs_sh[SYNC_STAGES-1];
  assign lr_s   = lr_sh[SYNC_STAGES-1];
  assign ev_d16 = 16'(ev_data);

  // Control lines idle high so reset looks like a deselected, idle bus.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_sh   <= '1;
      rs_sh   <= '1;
      cs_sh   <= '1;
      lr_sh   <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) d_sh[i] <= '0;
      wr_prev <= 1'b1;
      cs_prev <= 1'b1;
      ev_q    <= 1'b0;
      ev_rs   <= 1'b0;
      ev_data <= '0;
    end else begin
      wr_sh   <= {wr_sh[SYNC_STAGES-2:0], bus.i_lcd_wr_async};
      rs_sh   <= {rs_sh[SYNC_STAGES-2:0], bus.i_lcd_rs_async};
      cs_sh   <= {cs_sh[SYNC_STAGES-2:0], bus.i_lcd_cs_n_async};
      lr_sh   <= {lr_sh[SYNC_STAGES-2:0], bus.i_lcd_rst_n_async};
      d_sh[0] <= bus.i_lcd_data_async;
      for (int i = 1; i < SYNC_STAGES; i++) d_sh[i] <= d_sh[i-1];
      wr_prev <= wr_s;
      cs_prev <= cs_s;
      ev_q    <= wr_s & ~wr_prev & ~cs_s & lr_s;
      ev_rs   <= rs_s;
      ev_data <= d_sh[SYNC_STAGES-1];
    end
  end

  state_t            state, state_n;
  logic              phase, phase_n, pend, pend_n;
  logic [7:0]        hi, hi_n;
  logic [PIDX_W-1:0] pidx, pidx_n;
  logic [7:0]        cmd_q, cmd_n, par_q, par_n;
  logic [PIDX_W-1:0] pout_q, pout_n;
  logic [15:0]       rgb_q, rgb_n;
  logic              cl_q, cl_n, pl_q, pl_n, xl_q, xl_n, fs_q, fs_n;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= IDLE;
      phase  <= 1'b0;
      pend   <= 1'b0;
      hi     <= '0;
      pidx   <= '0;
      cmd_q  <= '0;
      par_q  <= '0;
      pout_q <= '0;
      rgb_q  <= '0;
      cl_q   <= 1'b0;
      pl_q   <= 1'b0;
      xl_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      state  <= state_n;
      phase  <= phase_n;
      pend   <= pend_n;
      hi     <= hi_n;
      pidx   <= pidx_n;
      cmd_q  <= cmd_n;
      par_q  <= par_n;
      pout_q <= pout_n;
      rgb_q  <= rgb_n;
      cl_q   <= cl_n;
      pl_q   <= pl_n;
      xl_q   <= xl_n;
      fs_q   <= fs_n;
    end
  end

  always_comb begin
    state_n = state;
    phase_n = phase;
    pend_n  = pend;
    hi_n    = hi;
    pidx_n  = pidx;
    cmd_n   = cmd_q;
    par_n   = par_q;
    pout_n  = pout_q;
    rgb_n   = rgb_q;
    cl_n    = 1'b0;
    pl_n    = 1'b0;
    xl_n    = 1'b0;
    fs_n    = 1'b0;
    if (!lr_s) begin
      state_n = IDLE;
      phase_n = 1'b0;
      pidx_n  = '0;
      pend_n  = 1'b0;
    end else begin
      if (cs_s && !cs_prev) phase_n = 1'b0;
      if (ev_q && !ev_rs) begin
        cmd_n   = ev_d16[7:0];
        cl_n    = 1'b1;
        pidx_n  = '0;
        phase_n = 1'b0;
        if (ev_d16[7:0] == CMD_RAMWR) begin
          state_n = PIXEL;
          pend_n  = 1'b1;
        end else if (ev_d16[7:0] == CMD_RAMWRC) begin
          state_n = PIXEL;
          pend_n  = 1'b0;
        end else begin
          state_n = PARAM;
        end
      end else if (ev_q) begin
        unique case (state)
          PARAM: begin
            par_n  = ev_d16[7:0];
            pout_n = pidx;
            pl_n   = 1'b1;
            if (pidx != '1) pidx_n = pidx + 1'b1;
          end
          PIXEL: begin
            if (BUS_WIDTH == 16) begin
              rgb_n = ev_d16;
              xl_n  = 1'b1;
            end else if (!phase) begin
              hi_n    = ev_d16[7:0];
              phase_n = 1'b1;
            end else begin
              rgb_n   = {hi, ev_d16[7:0]};
              xl_n    = 1'b1;
              phase_n = 1'b0;
            end
            if (xl_n && pend) begin
              fs_n   = 1'b1;
              pend_n = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.o_command       = cmd_q;
  assign bus.o_command_latch = cl_q;
  assign bus.o_param         = par_q;
  assign bus.o_param_idx     = pout_q;
  assign bus.o_param_latch   = pl_q;
  assign bus.o_rgb565        = rgb_q;
  assign bus.o_rgb565_latch  = xl_q;
  assign bus.o_frame_start   = fs_q;

endmodule

// File: tb/tb_lcd_rx_bus.sv
// Directed bench for lcd_rx_bus: 16-bit (2 and 3 sync stages) and 8-bit
// instances share one pin stimulus; pulses are collected into queues.
module tb_lcd_rx_bus;

  logic clk = 1'b0;
  logic rst;
  logic wr, rs, cs_n, lrst_n;
  logic [15:0] data;
  int checks = 0;
  int failures = 0;
  int multi = 0;

  always #5 clk = ~clk;

  lcd_rx_bus_if #(.BUS_WIDTH(16), .PIDX_W(4)) a_if ();
  lcd_rx_bus_if #(.BUS_WIDTH(16), .PIDX_W(4)) c_if ();
  lcd_rx_bus_if #(.BUS_WIDTH(8),  .PIDX_W(4)) b_if ();

  assign a_if.i_lcd_wr_async    = wr;
  assign a_if.i_lcd_rs_async    = rs;
  assign a_if.i_lcd_cs_n_async  = cs_n;
  assign a_if.i_lcd_rst_n_async = lrst_n;
  assign a_if.i_lcd_data_async  = data;
  assign c_if.i_lcd_wr_async    = wr;
  assign c_if.i_lcd_rs_async    = rs;
  assign c_if.i_lcd_cs_n_async  = cs_n;
  assign c_if.i_lcd_rst_n_async = lrst_n;
  assign c_if.i_lcd_data_async  = data;
  assign b_if.i_lcd_wr_async    = wr;
  assign b_if.i_lcd_rs_async    = rs;
  assign b_if.i_lcd_cs_n_async  = cs_n;
  assign b_if.i_lcd_rst_n_async = lrst_n;
  assign b_if.i_lcd_data_async  = data[7:0];

  lcd_rx_bus #(.BUS_WIDTH(16), .SYNC_STAGES(2)) dut_a (
    .i_clk(clk), .i_rst(rst), .bus(a_if.slave));
  lcd_rx_bus #(.BUS_WIDTH(16), .SYNC_STAGES(3)) dut_c (
    .i_clk(clk), .i_rst(rst), .bus(c_if.slave));
  lcd_rx_bus #(.BUS_WIDTH(8), .SYNC_STAGES(2)) dut_b (
    .i_clk(clk), .i_rst(rst), .bus(b_if.slave));

  logic [7:0]  cmd_q [$];
  logic [11:0] par_q [$];
  logic [16:0] pix_q [$];
  logic [16:0] pix8_q [$];

  always @(negedge clk) begin
    if (a_if.o_command_latch) cmd_q.push_back(a_if.o_command);
    if (a_if.o_param_latch)
      par_q.push_back({a_if.o_param_idx, a_if.o_param});
    if (a_if.o_rgb565_latch)
      pix_q.push_back({a_if.o_frame_start, a_if.o_rgb565});
    if (b_if.o_rgb565_latch)
      pix8_q.push_back({b_if.o_frame_start, b_if.o_rgb565});
    if (int'(a_if.o_command_latch) + int'(a_if.o_param_latch)
        + int'(a_if.o_rgb565_latch) > 1) multi++;
    if (int'(b_if.o_command_latch) + int'(b_if.o_param_latch)
        + int'(b_if.o_rgb565_latch) > 1) multi++;
  end

  task automatic clr_q();
    cmd_q.delete();
    par_q.delete();
    pix_q.delete();
    pix8_q.delete();
  endtask

  task automatic wr_cycle(input logic rs_v, input logic [15:0] d);
    @(negedge clk);
    wr = 1'b0;
    rs = rs_v;
    data = d;
    repeat (5) @(negedge clk);
    wr = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; wr = 1'b1; rs = 1'b1; cs_n = 1'b1;
    lrst_n = 1'b1; data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (a_if.o_command !== 8'h00 || a_if.o_command_latch !== 1'b0) begin
      failures++;
      $display("FAIL reset_cmd got=%h/%b exp=00/0",
               a_if.o_command, a_if.o_command_latch);
    end
    checks++;
    if (a_if.o_param !== 8'h00 || a_if.o_param_idx !== 4'h0
        || a_if.o_param_latch !== 1'b0) begin
      failures++;
      $display("FAIL reset_param got=%h/%h/%b exp=00/0/0",
               a_if.o_param, a_if.o_param_idx, a_if.o_param_latch);
    end
    checks++;
    if (a_if.o_rgb565 !== 16'h0 || a_if.o_rgb565_latch !== 1'b0
        || a_if.o_frame_start !== 1'b0) begin
      failures++;
      $display("FAIL reset_pix got=%h/%b/%b exp=0000/0/0", a_if.o_rgb565,
               a_if.o_rgb565_latch, a_if.o_frame_start);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_params();
    logic [7:0] pv [4];
    pv[0] = 8'h00; pv[1] = 8'h10; pv[2] = 8'h00; pv[3] = 8'hEF;
    clr_q();
    wr_cycle(1'b0, 16'h002A);
    for (int i = 0; i < 4; i++) wr_cycle(1'b1, {8'hA5, pv[i]});
    checks++;
    if (cmd_q.size() != 1 || cmd_q[0] !== 8'h2A) begin
      failures++;
      $display("FAIL param_cmd got=%0d/%h exp=1/2a", cmd_q.size(),
               cmd_q.size() > 0 ? cmd_q[0] : 8'hxx);
    end
    checks++;
    if (par_q.size() != 4) begin
      failures++;
      $display("FAIL param_count got=%0d exp=4", par_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (par_q[i] !== {4'(i), pv[i]}) begin
          failures++;
          $display("FAIL param_%0d got=%h exp=%h", i, par_q[i],
                   {4'(i), pv[i]});
        end
      end
    end
    checks++;
    if (pix_q.size() != 0) begin
      failures++;
      $display("FAIL param_nopix got=%0d exp=0", pix_q.size());
    end
  endtask

  task automatic test_pixels16();
    clr_q();
    wr_cycle(1'b0, 16'h002C);
    wr_cycle(1'b1, 16'hF800);
    wr_cycle(1'b1, 16'h07E0);
    wr_cycle(1'b0, 16'h003C);
    wr_cycle(1'b1, 16'h001F);
    checks++;
    if (pix_q.size() != 3) begin
      failures++;
      $display("FAIL pix16_count got=%0d exp=3", pix_q.size());
    end else begin
      checks++;
      if (pix_q[0] !== 17'h1F800) begin
        failures++;
        $display("FAIL pix16_0 got=%h exp=1f800", pix_q[0]);
      end
      checks++;
      if (pix_q[1] !== 17'h007E0) begin
        failures++;
        $display("FAIL pix16_1 got=%h exp=007e0", pix_q[1]);
      end
      checks++;
      if (pix_q[2] !== 17'h0001F) begin
        failures++;
        $display("FAIL pix16_ramwrc got=%h exp=0001f", pix_q[2]);
      end
    end
  endtask

  task automatic test_pixels8();
    clr_q();
    wr_cycle(1'b0, 16'h002C);
    wr_cycle(1'b1, 16'h00F8);
    wr_cycle(1'b1, 16'h0000);
    wr_cycle(1'b1, 16'h0007);
    wr_cycle(1'b1, 16'h00E0);
    checks++;
    if (pix8_q.size() != 2 || pix8_q[0] !== 17'h1F800
        || pix8_q[1] !== 17'h007E0) begin
      failures++;
      $display("FAIL pix8_pair got=%0d/%h/%h exp=2/1f800/007e0",
               pix8_q.size(), pix8_q.size() > 0 ? pix8_q[0] : 17'hx,
               pix8_q.size() > 1 ? pix8_q[1] : 17'hx);
    end
    clr_q();
    wr_cycle(1'b0, 16'h002C);
    wr_cycle(1'b1, 16'h00F8);
    cs_n = 1'b1;
    repeat (5) @(negedge clk);
    cs_n = 1'b0;
    repeat (5) @(negedge clk);
    wr_cycle(1'b1, 16'h0012);
    wr_cycle(1'b1, 16'h0034);
    checks++;
    if (pix8_q.size() != 1 || pix8_q[0] !== 17'h11234) begin
      failures++;
      $display("FAIL pix8_csdrop got=%0d/%h exp=1/11234", pix8_q.size(),
               pix8_q.size() > 0 ? pix8_q[0] : 17'hx);
    end
  endtask

  task automatic test_latency();
    int first2 = 0;
    int first3 = 0;
    @(negedge clk);
    wr = 1'b0; rs = 1'b0; data = 16'h0055;
    repeat (5) @(negedge clk);
    wr = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk);
      #1;
      if (a_if.o_command_latch && first2 == 0) first2 = n;
      if (c_if.o_command_latch && first3 == 0) first3 = n;
    end
    checks++;
    if (first2 != 4) begin
      failures++;
      $display("FAIL latency_s2 got=%0d exp=4", first2);
    end
    checks++;
    if (first3 != 5) begin
      failures++;
      $display("FAIL latency_s3 got=%0d exp=5", first3);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_param_sat();
    clr_q();
    wr_cycle(1'b0, 16'h00B1);
    for (int i = 0; i < 17; i++) wr_cycle(1'b1, 16'(i));
    checks++;
    if (par_q.size() != 17) begin
      failures++;
      $display("FAIL sat_count got=%0d exp=17", par_q.size());
    end else begin
      checks++;
      if (par_q[14] !== 12'hE0E) begin
        failures++;
        $display("FAIL sat_14 got=%h exp=e0e", par_q[14]);
      end
      checks++;
      if (par_q[15] !== 12'hF0F) begin
        failures++;
        $display("FAIL sat_15 got=%h exp=f0f", par_q[15]);
      end
      checks++;
      if (par_q[16] !== 12'hF10) begin
        failures++;
        $display("FAIL sat_16 got=%h exp=f10", par_q[16]);
      end
    end
  endtask

  task automatic test_lcd_reset();
    wr_cycle(1'b0, 16'h002A);
    clr_q();
    @(negedge clk);
    lrst_n = 1'b0;
    repeat (6) @(negedge clk);
    lrst_n = 1'b1;
    repeat (6) @(negedge clk);
    wr_cycle(1'b1, 16'h0077);
    checks++;
    if (par_q.size() != 0 || cmd_q.size() != 0) begin
      failures++;
      $display("FAIL lcdrst_idle got=%0d/%0d exp=0/0", par_q.size(),
               cmd_q.size());
    end
    checks++;
    if (a_if.o_param !== 8'h10 || a_if.o_command !== 8'h2A) begin
      failures++;
      $display("FAIL lcdrst_hold got=%h/%h exp=10/2a", a_if.o_param,
               a_if.o_command);
    end
  endtask

  task automatic test_cs_high();
    clr_q();
    @(negedge clk);
    cs_n = 1'b1;
    wr_cycle(1'b0, 16'hABCD);
    wr_cycle(1'b1, 16'hABCD);
    wr_cycle(1'b1, 16'hABCD);
    checks++;
    if (cmd_q.size() + par_q.size() + pix_q.size() + pix8_q.size() != 0)
    begin
      failures++;
      $display("FAIL cs_high_pulses got=%0d exp=0",
               cmd_q.size() + par_q.size() + pix_q.size() + pix8_q.size());
    end
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_rst_mid();
    logic seen = 1'b0;
    wr_cycle(1'b0, 16'h002C);
    @(negedge clk);
    wr = 1'b0; rs = 1'b1; data = 16'hF800;
    repeat (5) @(negedge clk);
    wr = 1'b1;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(posedge clk);
      #1;
      seen = a_if.o_rgb565_latch;
    end
    checks++;
    if (seen !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pulse got=%b exp=1", seen);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (a_if.o_rgb565_latch !== 1'b0 || a_if.o_frame_start !== 1'b0
        || a_if.o_rgb565 !== 16'h0) begin
      failures++;
      $display("FAIL rstmid_pix got=%b/%b/%h exp=0/0/0000",
               a_if.o_rgb565_latch, a_if.o_frame_start, a_if.o_rgb565);
    end
    checks++;
    if (a_if.o_command !== 8'h00 || a_if.o_param !== 8'h00) begin
      failures++;
      $display("FAIL rstmid_regs got=%h/%h exp=00/00", a_if.o_command,
               a_if.o_param);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_params();
    test_pixels16();
    test_pixels8();
    test_latency();
    test_param_sat();
    test_lcd_reset();
    test_cs_high();
    test_rst_mid();
    checks++;
    if (multi != 0) begin
      failures++;
      $display("FAIL one_latch got=%0d exp=0", multi);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
